// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read, EX/MEM forwarding, PC+8 substitution, load-use bubble.
// Optional statistics counters (stall_cnt, bubble_cnt, fwd_cnt) are built when OPF_STATS_EN is defined.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_REG = 15
`ifdef OPF_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic              in_use_rn,
  input  logic              in_use_rm,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_pc_plus8,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_is_load
`ifdef OPF_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state, state_nxt;
  logic              capture, valid_nxt, hazard;
  logic              pc_a, pc_b, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic              lu_a, lu_b;
  logic [DATA_W-1:0] sel_a, sel_b;

  assign rf_addr1 = in_rn;
  assign rf_addr2 = in_rm;

  // Source match decode; PC reads never forward and never stall.
  assign pc_a      = in_use_rn && (in_rn == PC_IDX);
  assign pc_b      = in_use_rm && (in_rm == PC_IDX);
  assign ex_hit_a  = in_use_rn && !pc_a && ex_wr_en && !ex_is_load && (ex_wr_addr == in_rn);
  assign ex_hit_b  = in_use_rm && !pc_b && ex_wr_en && !ex_is_load && (ex_wr_addr == in_rm);
  assign mem_hit_a = in_use_rn && !pc_a && mem_wr_en && (mem_wr_addr == in_rn);
  assign mem_hit_b = in_use_rm && !pc_b && mem_wr_en && (mem_wr_addr == in_rm);
  assign lu_a      = in_use_rn && !pc_a && ex_wr_en && ex_is_load && (ex_wr_addr == in_rn);
  assign lu_b      = in_use_rm && !pc_b && ex_wr_en && ex_is_load && (ex_wr_addr == in_rm);
  assign hazard    = in_valid && (lu_a || lu_b);

  always_comb begin
    sel_a = rf_data1;
    if (pc_a)           sel_a = in_pc_plus8;
    else if (ex_hit_a)  sel_a = ex_result;
    else if (mem_hit_a) sel_a = mem_result;
  end

  always_comb begin
    sel_b = rf_data2;
    if (pc_b)           sel_b = in_pc_plus8;
    else if (ex_hit_b)  sel_b = ex_result;
    else if (mem_hit_b) sel_b = mem_result;
  end

  // Next-state, handshake and capture control; flush overrides everything.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    valid_nxt = out_valid && !out_ready;
    if (flush) begin
      state_nxt = RUN;
      valid_nxt = 1'b0;
    end else if (state == STALL) begin
      state_nxt = RUN;
    end else if (out_valid && !out_ready) begin
      valid_nxt = 1'b1;
    end else if (in_valid && !hazard) begin
      capture   = 1'b1;
      in_ready  = 1'b1;
      valid_nxt = 1'b1;
    end else if (hazard) begin
      state_nxt = STALL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_is_load   <= 1'b0;
    end else begin
      out_valid <= valid_nxt;
      if (capture) begin
        op_a          <= sel_a;
        op_b          <= sel_b;
        out_rd        <= in_rd;
        out_reg_write <= in_reg_write;
        out_is_load   <= in_is_load;
      end
    end
  end

`ifdef OPF_STATS_EN
  logic [1:0]     fwd_inc;
  logic [CNT_W:0] fwd_sum;

  assign fwd_inc = capture ? ({1'b0, ex_hit_a || mem_hit_a} + {1'b0, ex_hit_b || mem_hit_b}) : 2'd0;
  assign fwd_sum = {1'b0, fwd_cnt} + (CNT_W + 1)'(fwd_inc);

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      fwd_cnt    <= '0;
    end else begin
      if (state == RUN && state_nxt == STALL && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && in_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      fwd_cnt <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    end
  end
`endif

endmodule
